// File: rtl/instr_fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
// The fetch FSM only leaves FS_RUN when IFETCH_MISALIGN_CHECK_EN is defined.
package instr_fetch_pkg;

  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [0:0] {
    FS_RUN   = 1'b0,
    FS_FAULT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer with flush; head is presented from storage
// registers and reads as zero while the buffer is empty.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full buffer can still take a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: credit-limited sequential fetch, in-order response buffering and redirect handling.
// Define IFETCH_MISALIGN_CHECK_EN to trap misaligned redirect targets instead of silently aligning them.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT),
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  misalign_fault
);

  localparam int                    CW         = $clog2(FIFO_DEPTH) + 1;
  localparam int                    EW         = DATA_WIDTH + ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(INSTR_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(INSTR_BYTES - 1);

  fetch_state_e          state;
  fetch_state_e          state_next;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] resp_pc;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         drop_cnt;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           credits_used;
  logic                  credit_ok;
  logic                  req_fire;
  logic                  rsp_push;
  logic                  instr_pop;
  logic                  fifo_empty;
  logic                  redirect_misaligned;
  logic [ADDR_WIDTH-1:0] redirect_target;
  logic [EW-1:0]         fifo_head;

  assign redirect_target = redirect_pc & ALIGN_MASK;

`ifdef IFETCH_MISALIGN_CHECK_EN
  assign redirect_misaligned = (redirect_pc & ~ALIGN_MASK) != '0;
  assign misalign_fault      = (state == FS_FAULT);
`else
  assign redirect_misaligned = 1'b0;
  assign misalign_fault      = 1'b0;
`endif

  // Every in-flight fetch owns a buffer slot, so a response can never find the FIFO full.
  assign credits_used = {1'b0, outstanding} + {1'b0, fifo_count};
  assign credit_ok    = credits_used < (CW + 1)'(FIFO_DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FS_RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    imem_req_valid = 1'b0;
    if (redirect_valid) begin
      state_next = redirect_misaligned ? FS_FAULT : FS_RUN;
    end
    if (rst_n && (state == FS_RUN) && !redirect_valid && credit_ok) begin
      imem_req_valid = 1'b1;
    end
  end

  assign imem_req_addr = fetch_pc;
  assign req_fire      = imem_req_valid && imem_req_ready;
  assign rsp_push      = imem_rsp_valid && !redirect_valid && (drop_cnt == '0) && (state == FS_RUN);
  assign instr_pop     = instr_valid && instr_ready && !redirect_valid;

  // Responses still owed when a redirect lands belong to the old stream and are counted off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        fetch_pc <= redirect_target;
        resp_pc  <= redirect_target;
        drop_cnt <= outstanding - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + PC_STEP;
        end
        if (rsp_push) begin
          resp_pc <= resp_pc + PC_STEP;
        end
        if (imem_rsp_valid && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
      end
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (rsp_push),
    .push_data ({imem_rsp_data, resp_pc}),
    .pop       (instr_pop),
    .head_data (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign instr_valid = !fifo_empty;
  assign instr       = fifo_head[EW-1:ADDR_WIDTH];
  assign instr_pc    = fifo_head[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a variable-latency in-order imem model and a PC stream model.
// Scenario 5 follows IFETCH_MISALIGN_CHECK_EN the same way the design does.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        misalign_fault;

  int          checkCount = 0;
  int          errorCount = 0;
  int          cyc = 0;
  int          memLat = 1;
  int          accCount = 0;
  int          popCount = 0;
  logic [31:0] expReqPc = RST_PC;
  logic [31:0] expInstrPc = RST_PC;
  logic [31:0] firstPopPc = '0;
  logic [31:0] lastPopPc = '0;
  logic        svReqValid, svInstrValid, svFault;
  logic [31:0] svReqAddr, svInstrPc;
  pend_t       pendQ[$];

  instr_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .misalign_fault (misalign_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return 32'hC0DE_0000 ^ (a * 32'd3);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, sample at the falling edge, advance the imem model after the rising edge.
  task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic qr, input logic ir);
    logic        acc;
    logic [31:0] accAddr;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_req_ready = qr;
    instr_ready    = ir;
    @(negedge clk);
    svReqValid   = imem_req_valid;
    svReqAddr    = imem_req_addr;
    svInstrValid = instr_valid;
    svInstrPc    = instr_pc;
    svFault      = misalign_fault;
    acc          = imem_req_valid && imem_req_ready;
    accAddr      = imem_req_addr;
    if (acc) begin
      checkOutput("req_addr", imem_req_addr, expReqPc);
      expReqPc = expReqPc + 32'd4;
      accCount++;
    end
    if (instr_valid && instr_ready && !rv) begin
      checkOutput("instr_pc", instr_pc, expInstrPc);
      checkOutput("instr", instr, memWord(expInstrPc));
      if (popCount == 0) firstPopPc = instr_pc;
      lastPopPc  = instr_pc;
      expInstrPc = expInstrPc + 32'd4;
      popCount++;
    end
    if (rv) begin
      expReqPc   = rpc & ~32'h3;
      expInstrPc = rpc & ~32'h3;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (acc) pendQ.push_back('{accAddr, cyc - 1 + memLat});
    if (pendQ.size() > 0 && pendQ[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memWord(pendQ[0].addr);
      void'(pendQ.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  // Asynchronous reset pulse; outputs are checked while reset is still asserted.
  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("rst_req_addr", imem_req_addr, RST_PC);
    checkOutput("rst_instr_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_instr", instr, 32'd0);
    checkOutput("rst_instr_pc", instr_pc, 32'd0);
    checkOutput("rst_fault", 32'(misalign_fault), 32'd0);
    pendQ.delete();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    instr_ready    = 1'b0;
    expReqPc       = RST_PC;
    expInstrPc     = RST_PC;
    accCount       = 0;
    popCount       = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    instr_ready    = 1'b0;
    #2;

    // 1: first fetches and latency
    doReset();
    memLat = 1;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("t1_c0_req_valid", 32'(svReqValid), 32'd1);
    checkOutput("t1_c0_addr", svReqAddr, 32'h0);
    checkOutput("t1_c0_instr_valid", 32'(svInstrValid), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("t1_c1_addr", svReqAddr, 32'h4);
    checkOutput("t1_c1_instr_valid", 32'(svInstrValid), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("t1_c2_instr_valid", 32'(svInstrValid), 32'd1);
    checkOutput("t1_c2_instr_pc", svInstrPc, 32'h0);
    checkOutput("t1_c2_credit_stall", 32'(svReqValid), 32'd0);
    repeat (8) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("t1_accepts", 32'(accCount), 32'd8);
    checkOutput("t1_pops", 32'(popCount), 32'd6);

    // 2: decoder stall fills the credits
    doReset();
    repeat (10) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("t2_accepts", 32'(accCount), 32'd2);
    checkOutput("t2_stalled", 32'(svReqValid), 32'd0);
    checkOutput("t2_held", 32'(svInstrPc), 32'h0);
    repeat (4) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("t2_pops", 32'(popCount), 32'd3);
    checkOutput("t2_last_pc", lastPopPc, 32'h8);

    // 3: redirect with two responses still owed
    doReset();
    memLat = 3;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("t3_inflight", 32'(accCount), 32'd2);
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b1);
    popCount = 0;
    repeat (10) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("t3_popped", 32'(popCount > 0), 32'd1);
    checkOutput("t3_first_pc", firstPopPc, 32'h100);

    // 4: redirect, response and decode handshake together
    doReset();
    memLat = 1;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    popCount = 0;
    applyStimulus(1'b1, 32'h200, 1'b1, 1'b1);
    checkOutput("t4_head_present", 32'(svInstrValid), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("t4_flushed", 32'(svInstrValid), 32'd0);
    repeat (5) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("t4_popped", 32'(popCount > 0), 32'd1);
    checkOutput("t4_first_pc", firstPopPc, 32'h200);

    // 5: misaligned redirect
    doReset();
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h102, 1'b1, 1'b1);
`ifdef IFETCH_MISALIGN_CHECK_EN
    accCount = 0;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("t5_fault_set", 32'(svFault), 32'd1);
    checkOutput("t5_no_req", 32'(svReqValid), 32'd0);
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("t5_fault_held", 32'(svFault), 32'd1);
    checkOutput("t5_no_accepts", 32'(accCount), 32'd0);
    checkOutput("t5_no_instr", 32'(svInstrValid), 32'd0);
    applyStimulus(1'b1, 32'h200, 1'b1, 1'b1);
    popCount = 0;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("t5_fault_clear", 32'(svFault), 32'd0);
    checkOutput("t5_req_valid", 32'(svReqValid), 32'd1);
    checkOutput("t5_req_addr", svReqAddr, 32'h200);
    repeat (4) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("t5_first_pc", firstPopPc, 32'h200);
`else
    popCount = 0;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("t5_fault_tied", 32'(svFault), 32'd0);
    checkOutput("t5_req_valid", 32'(svReqValid), 32'd1);
    checkOutput("t5_req_addr", svReqAddr, 32'h100);
    repeat (4) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("t5_first_pc", firstPopPc, 32'h100);
`endif

    // 6: random stalls with a reset in the middle of a burst
    doReset();
    memLat = 2;
    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        checkOutput("t6_progress_a", 32'(popCount > 5), 32'd1);
        doReset();
      end
      applyStimulus(1'b0, 32'h0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
    end
    checkOutput("t6_progress_b", 32'(popCount > 5), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
